l2_victim_sel: RTL and testbench

- Downstream of the L2 lookup stage. Consumes the registered hit and empty-way results for a request's set and returns the way the L2 FSM uses for the request.
- Way choice, in order: hit way, else usable empty way, else eviction victim. The victim comes from a per-set round-robin pointer and skips ways locked by in-flight transactions.
- Holds the per-set eviction pointer table.
- Reports a stall when every way in the set is locked.

---
 rtl/l2_victim_sel.sv | 136 +++++++++++++
 tb/tb_l2_victim_sel.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/l2_victim_sel.sv
// L2 way selection: hit way, else an unlocked empty way, else a round-robin victim.
// Locked ways are skipped, and a per-set eviction pointer table is kept.
module l2_victim_sel #(
  parameter int L2_WAYS  = 8,
  parameter int L2_SETS  = 256,
  parameter int WAY_BITS = 3,
  parameter int SET_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  output logic                sel_ready,
  input  logic [SET_BITS-1:0] sel_set,
  input  logic                tag_hit,
  input  logic [WAY_BITS-1:0] way_hit,
  input  logic                empty_way_found,
  input  logic [WAY_BITS-1:0] empty_way,
  input  logic [L2_WAYS-1:0]  way_lock_mask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WAY_BITS-1:0] resp_way,
  output logic                resp_evict,
  output logic                resp_stall,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens at a rising edge where valid && ready.
  // The response fields stay stable while resp_valid is high and resp_ready is low.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [WAY_BITS-1:0] K_LAST = WAY_BITS'(L2_WAYS - 1);

  state_e                state_q, state_d;
  logic [SET_BITS-1:0]   set_q, set_d;
  logic [WAY_BITS-1:0]   p_q, p_d;
  logic [WAY_BITS-1:0]   k_q, k_d;
  logic [WAY_BITS-1:0]   way_q, way_d;
  logic                  evict_q, evict_d;
  logic                  stall_q, stall_d;
  logic [WAY_BITS-1:0]   ptr_q [L2_SETS];
  logic [WAY_BITS-1:0]   ptr_d [L2_SETS];
  logic [WAY_BITS-1:0]   cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      set_q   <= '0;
      p_q     <= '0;
      k_q     <= '0;
      way_q   <= '0;
      evict_q <= 1'b0;
      stall_q <= 1'b0;
      for (int i = 0; i < L2_SETS; i++) ptr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      p_q     <= p_d;
      k_q     <= k_d;
      way_q   <= way_d;
      evict_q <= evict_d;
      stall_q <= stall_d;
      ptr_q   <= ptr_d;
    end
  end

  // The candidate wraps naturally through WAY_BITS truncation.
  assign cand = p_q + k_q;

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    p_d     = p_q;
    k_d     = k_q;
    way_d   = way_q;
    evict_d = evict_q;
    stall_d = stall_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          set_d   = sel_set;
          p_d     = ptr_q[sel_set];
          k_d     = '0;
          evict_d = 1'b0;
          stall_d = 1'b0;
          if (tag_hit) begin
            way_d   = way_hit;
            state_d = RESP;
          end else if (empty_way_found && !way_lock_mask[empty_way]) begin
            way_d   = empty_way;
            state_d = RESP;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        // The lock mask is live: a way unlocked behind the scan is not revisited.
        if (!way_lock_mask[cand]) begin
          way_d   = cand;
          evict_d = 1'b1;
          stall_d = 1'b0;
          state_d = RESP;
        end else if (k_q == K_LAST) begin
          way_d   = p_q;
          evict_d = 1'b0;
          stall_d = 1'b1;
          state_d = RESP;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          if (evict_q) ptr_d[set_q] = way_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_way   = way_q;
    resp_evict = evict_q;
    resp_stall = stall_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_l2_victim_sel.sv
// Directed bench for l2_victim_sel: the driver queues the expected response and its latency,
// and a monitor checks each response when it appears and while it is held.
module tb_l2_victim_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_valid = 1'b0;
  logic       sel_ready;
  logic [7:0] sel_set = '0;
  logic       tag_hit = 1'b0;
  logic [2:0] way_hit = '0;
  logic       empty_way_found = 1'b0;
  logic [2:0] empty_way = '0;
  logic [7:0] way_lock_mask = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [2:0] resp_way;
  logic       resp_evict;
  logic       resp_stall;
  logic [1:0] dbg_state;

  l2_victim_sel dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_ready(sel_ready),
    .sel_set(sel_set), .tag_hit(tag_hit), .way_hit(way_hit),
    .empty_way_found(empty_way_found), .empty_way(empty_way),
    .way_lock_mask(way_lock_mask), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_way(resp_way), .resp_evict(resp_evict), .resp_stall(resp_stall),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  int         lat_q[$];
  int         acc_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  logic       seen = 1'b0;
  logic [4:0] cur_exp = '0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (resp_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          int lat;
          cur_exp = exp_q.pop_front();
          lat = lat_q.pop_front();
          chk("resp_way", int'(resp_way), int'(cur_exp[4:2]));
          chk("resp_evict", int'(resp_evict), int'(cur_exp[1]));
          chk("resp_stall", int'(resp_stall), int'(cur_exp[0]));
          chk("latency", cyc - acc_cyc + 1, lat);
        end
      end else begin
        chk("hold_fields", int'({resp_way, resp_evict, resp_stall}), int'(cur_exp));
        chk("hold_sel_ready", int'(sel_ready), 0);
      end
    end else begin
      seen = 1'b0;
    end
  end

  // driver tasks
  task automatic issue(input logic [7:0] s, input logic hit, input logic [2:0] wh,
                       input logic ef, input logic [2:0] ew, input logic [7:0] lk,
                       input logic [2:0] xw, input logic xe, input logic xs, input int xl);
    @(negedge clk);
    sel_set = s; tag_hit = hit; way_hit = wh;
    empty_way_found = ef; empty_way = ew; way_lock_mask = lk;
    sel_valid = 1'b1;
    exp_q.push_back({xw, xe, xs});
    lat_q.push_back(xl);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < 60 && !(exp_q.size() == 0 && sel_ready && !resp_valid)) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 60) begin
      chk("timeout", 1, 0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic run(input logic [7:0] s, input logic hit, input logic [2:0] wh,
                     input logic ef, input logic [2:0] ew, input logic [7:0] lk,
                     input logic [2:0] xw, input logic xe, input logic xs, input int xl);
    issue(s, hit, wh, ef, ew, lk, xw, xe, xs, xl);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel_ready", int'(sel_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_way", int'(resp_way), 0);
    chk("rst_resp_evict", int'(resp_evict), 0);
    chk("rst_resp_stall", int'(resp_stall), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // hit wins even when every way is locked
    run(8'd0, 1'b1, 3'd5, 1'b0, 3'd0, 8'hFF, 3'd5, 1'b0, 1'b0, 1);
    // unlocked empty way, one cycle
    run(8'd0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h00, 3'd2, 1'b0, 1'b0, 1);
    // empty way locked: scan from untouched ptr 0
    run(8'd0, 1'b0, 3'd0, 1'b1, 3'd2, 8'h04, 3'd0, 1'b1, 1'b0, 2);
    // set 7: ways 0..2 locked -> way 3 at N+5, ptr becomes 4
    run(8'd7, 1'b0, 3'd0, 1'b0, 3'd0, 8'h07, 3'd3, 1'b1, 1'b0, 5);
    run(8'd7, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd4, 1'b1, 1'b0, 2);
    // set 3: drive ptr to 6, then wrap past 6,7,0 to way 1
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h1F, 3'd5, 1'b1, 1'b0, 7);
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'hC1, 3'd1, 1'b1, 1'b0, 5);
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd2, 1'b1, 1'b0, 2);
    // set 3 ptr now 3: all locked stalls at N+9 and leaves the pointer alone
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'hFF, 3'd3, 1'b0, 1'b1, 9);
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd3, 1'b1, 1'b0, 2);
    // set 0 ptr is 1 after the earlier eviction
    run(8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd1, 1'b1, 1'b0, 2);

    // backpressure: hold for 10 cycles with a competing request on sel_valid
    resp_ready = 1'b0;
    issue(8'd5, 1'b1, 3'd6, 1'b0, 3'd0, 8'h00, 3'd6, 1'b0, 1'b0, 1);
    sel_set = 8'd1; tag_hit = 1'b1; way_hit = 3'd2; sel_valid = 1'b1;
    repeat (10) @(negedge clk);
    sel_valid = 1'b0;
    resp_ready = 1'b1;
    wait_done();

    // reset in the middle of a scan (set 7 ptr is 5 at this point)
    @(negedge clk);
    sel_set = 8'd7; tag_hit = 1'b0; empty_way_found = 1'b0; way_lock_mask = 8'hFF;
    sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("scan_state", int'(dbg_state), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sel_ready", int'(sel_ready), 1);
    chk("mid_rst_resp_valid", int'(resp_valid), 0);
    chk("mid_rst_resp_way", int'(resp_way), 0);
    chk("mid_rst_resp_evict", int'(resp_evict), 0);
    chk("mid_rst_resp_stall", int'(resp_stall), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // pointers cleared by reset
    run(8'd7, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b1, 1'b0, 2);
    run(8'd3, 1'b0, 3'd0, 1'b0, 3'd0, 8'h00, 3'd0, 1'b1, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
